// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - HD44780 4-bit read engine: status / data-RAM byte read with optional busy-flag poll
//
// Optional feature macro: LCD_BUSY_POLL_EN (busy-flag polling; poll_done/poll_timeout tied to 0 when undefined)
//
// Ports:
//   CLK, RST        system clock, synchronous active-high reset
//   rd_req, rd_rs   start a read (sampled in IDLE); 0 = status read, 1 = data-RAM read
//   rd_busy         transaction in progress
//   rd_valid        one-cycle pulse, rd_data updated
//   rd_data         last byte read (high nibble read first)
//   busy_flag       bit 7 of the last status read
//   lcd_din         {SF_D, SF_C, SF_B, SF_A} pad inputs
//   LCD_E/RS/RW     LCD control pins; SF_E holds the StrataFlash disabled
//   poll_req        start a busy-flag poll
//   poll_done       one-cycle pulse when a poll ends
//   poll_timeout    one-cycle pulse with poll_done when the poll gave up
module lcd_reader #(
    parameter int T_SETUP  = 2,
    parameter int T_EPW    = 12,
    parameter int T_GAP    = 50,
    parameter int POLL_MAX = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rd_req,
    input  logic       rd_rs,
    output logic       rd_busy,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    input  logic [3:0] lcd_din,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       SF_E,
    input  logic       poll_req,
    output logic       poll_done,
    output logic       poll_timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP_H, S_EHI_H, S_GAP_H, S_SETUP_L, S_EHI_L, S_GAP_L, S_DONE
    } state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] EPW_LAST   = CW'(T_EPW - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(T_GAP - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    hi_q, hi_d, lo_q, lo_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          busy_flag_q, busy_flag_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_busy_q, rd_busy_d;
    logic          rs_q, rs_d;
    logic          e_q, e_d;
    logic          rw_q, rw_d;

`ifdef LCD_BUSY_POLL_EN
    localparam int PCW = $clog2(POLL_MAX + 1);
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
    logic           polling_q, polling_d;
    logic           poll_done_q, poll_done_d;
    logic           poll_timeout_q, poll_timeout_d;
`else
    logic unused_poll;
    assign unused_poll = poll_req ^ (POLL_MAX > 0);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        hi_d        = hi_q;
        lo_d        = lo_q;
        rs_d        = rs_q;
        rd_data_d   = rd_data_q;
        busy_flag_d = busy_flag_q;
        rd_valid_d  = 1'b0;
`ifdef LCD_BUSY_POLL_EN
        polling_d      = polling_q;
        poll_cnt_d     = poll_cnt_q;
        poll_done_d    = 1'b0;
        poll_timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
`ifdef LCD_BUSY_POLL_EN
                // A poll outranks a plain read and always reads status.
                if (poll_req) begin
                    state_d    = S_SETUP_H;
                    rs_d       = 1'b0;
                    polling_d  = 1'b1;
                    poll_cnt_d = '0;
                end else
`endif
                if (rd_req) begin
                    state_d = S_SETUP_H;
                    rs_d    = rd_rs;
                end
            end
            S_SETUP_H: if (cnt_q == SETUP_LAST) begin state_d = S_EHI_H; cnt_d = '0; end
            S_EHI_H: if (cnt_q == EPW_LAST) begin
                // Sample at the end of the pulse, when the LCD output is settled.
                hi_d    = lcd_din;
                state_d = S_GAP_H;
                cnt_d   = '0;
            end
            S_GAP_H:   if (cnt_q == GAP_LAST) begin state_d = S_SETUP_L; cnt_d = '0; end
            S_SETUP_L: if (cnt_q == SETUP_LAST) begin state_d = S_EHI_L; cnt_d = '0; end
            S_EHI_L: if (cnt_q == EPW_LAST) begin
                lo_d    = lcd_din;
                state_d = S_GAP_L;
                cnt_d   = '0;
            end
            S_GAP_L: if (cnt_q == GAP_LAST) begin
                state_d    = S_DONE;
                cnt_d      = '0;
                rd_valid_d = 1'b1;
                rd_data_d  = {hi_q, lo_q};
                if (!rs_q) busy_flag_d = hi_q[3];
                rs_d       = 1'b0;
`ifdef LCD_BUSY_POLL_EN
                if (polling_q) begin
                    poll_cnt_d = poll_cnt_q + 1'b1;
                    if (!hi_q[3]) begin
                        poll_done_d = 1'b1;
                        polling_d   = 1'b0;
                    end else if (poll_cnt_q == PCW'(POLL_MAX - 1)) begin
                        poll_done_d    = 1'b1;
                        poll_timeout_d = 1'b1;
                        polling_d      = 1'b0;
                    end
                end
`endif
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
`ifdef LCD_BUSY_POLL_EN
                // Polls chain reads without an IDLE cycle in between.
                if (polling_q) state_d = S_SETUP_H;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Pin values are derived from the next state so every output is a flop.
        e_d       = (state_d == S_EHI_H) || (state_d == S_EHI_L);
        rw_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        rd_busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
`ifdef LCD_BUSY_POLL_EN
        if ((state_d == S_DONE) && polling_d) rd_busy_d = 1'b1;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            rs_q        <= 1'b0;
            rd_data_q   <= '0;
            busy_flag_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_busy_q   <= 1'b0;
            e_q         <= 1'b0;
            rw_q        <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            polling_q      <= 1'b0;
            poll_cnt_q     <= '0;
            poll_done_q    <= 1'b0;
            poll_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            rs_q        <= rs_d;
            rd_data_q   <= rd_data_d;
            busy_flag_q <= busy_flag_d;
            rd_valid_q  <= rd_valid_d;
            rd_busy_q   <= rd_busy_d;
            e_q         <= e_d;
            rw_q        <= rw_d;
`ifdef LCD_BUSY_POLL_EN
            polling_q      <= polling_d;
            poll_cnt_q     <= poll_cnt_d;
            poll_done_q    <= poll_done_d;
            poll_timeout_q <= poll_timeout_d;
`endif
        end
    end

    assign rd_busy   = rd_busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign busy_flag = busy_flag_q;
    assign LCD_E     = e_q;
    assign LCD_RS    = rs_q;
    assign LCD_RW    = rw_q;
    assign SF_E      = 1'b1;
`ifdef LCD_BUSY_POLL_EN
    assign poll_done    = poll_done_q;
    assign poll_timeout = poll_timeout_q;
`else
    assign poll_done    = 1'b0;
    assign poll_timeout = 1'b0;
`endif

endmodule

// File: doc/lcd_reader.md
# lcd_reader

Read-side engine for the Spartan-3E character LCD (HD44780-compatible, 4-bit bus shared with StrataFlash). It performs one read transaction on request: status read (busy flag plus address counter) or data-RAM read. It generates RS/RW/E timing, samples two nibbles from SF_D..SF_A and returns one byte. It sits beside the LCD write sequencer; the top level gives the bus to the writer whenever `LCD_RW` is 0.

## Interface
Parameters:
- `T_SETUP`, default 2: cycles RS/RW are stable before E rises (≥1).
- `T_EPW`, default 12: E high cycles per nibble (≥2); 240 ns at 50 MHz.
- `T_GAP`, default 50: E low cycles after each nibble (≥1).
- `POLL_MAX`, default 255: maximum status reads per poll (only used when `LCD_BUSY_POLL_EN` is defined).

Ports:
- `CLK`  in  1  system clock, 50 MHz. One clock; reset is synchronous and active-high.
- `RST`  in  1  synchronous, active-high reset.
- `rd_req`  in  1  start a read; sampled only in IDLE.
- `rd_rs`  in  1  0 = status read, 1 = data-RAM read; captured with `rd_req`.
- `rd_busy`  out  1  transaction in progress.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` updated.
- `rd_data`  out  8  last byte read; high nibble is read first.
- `busy_flag`  out  1  bit 7 of the last status read.
- `lcd_din`  in  4  {SF_D, SF_C, SF_B, SF_A} pad inputs.
- `LCD_E`, `LCD_RS`, `LCD_RW`  out  1 each  LCD control pins.
- `SF_E`  out  1  StrataFlash disable; held at 1.
- `poll_req`  in  1  start a busy-flag poll.
- `poll_done`  out  1  one-cycle pulse when the poll ends.
- `poll_timeout`  out  1  one-cycle pulse, coincident with `poll_done`, when the poll gave up.

## Operation
- States: IDLE → SETUP_H → EHI_H → GAP_H → SETUP_L → EHI_L → GAP_L → DONE → IDLE.
- IDLE:
  - `rd_req`=1 captures `rd_rs` into `LCD_RS` and sets `LCD_RW`=1.
  - `rd_busy` rises on the next cycle.
- SETUP_x: `LCD_E`=0 for `T_SETUP` cycles.
- EHI_x:
  - `LCD_E`=1 for `T_EPW` cycles.
  - `lcd_din` is registered on the final EHI cycle: into bits [7:4] in EHI_H, into bits [3:0] in EHI_L.
- GAP_x: `LCD_E`=0 for `T_GAP` cycles.
- DONE (one cycle):
  - `rd_valid`=1; `rd_data` is updated.
  - `busy_flag` takes `rd_data[7]` for status reads only; it is unchanged on data reads.
  - `LCD_RW` returns to 0 and `LCD_RS` returns to 0.
  - `rd_busy` falls.
- `LCD_RW`=1 from the cycle after acceptance through the last GAP_L cycle. The FPGA must not drive the bus during this window.
- `rd_req` asserted while busy is ignored; requests are not queued.
- `rd_req` held high produces back-to-back reads: a new request is accepted in the IDLE cycle after DONE.
- `rd_req` and `poll_req` asserted together in IDLE: `poll_req` wins.
- Reset values: `LCD_E`=0, `LCD_RS`=0, `LCD_RW`=0, `SF_E`=1, `rd_busy`=0, `rd_valid`=0, `rd_data`=0x00, `busy_flag`=0, `poll_done`=0, `poll_timeout`=0.
- `RST` mid-transaction:
  - The block is in IDLE with reset values on the next cycle, including `LCD_E`=0.
  - No `rd_valid` is produced.

## Timing
- Request accepted at edge k.
- `rd_valid` high in cycle k + 2·(`T_SETUP`+`T_EPW`+`T_GAP`) + 1. With defaults this is k+129.
- Every E pulse is exactly `T_EPW` cycles wide.
- E-to-E rising spacing is `T_EPW`+`T_GAP`+`T_SETUP` = 64 cycles (1.28 µs, meets the ≥1 µs cycle time).
- All outputs are registered; no combinational path from any input to any output.

## Configuration
`LCD_BUSY_POLL_EN`:
- Defined:
  - `poll_req` in IDLE starts repeated status reads with RS forced to 0 and no IDLE cycle between reads.
  - Polling ends when a read returns bit 7 = 0: `poll_done` pulses in that read's DONE cycle.
  - Polling also ends after `POLL_MAX` reads with bit 7 = 1: `poll_done` and `poll_timeout` pulse together.
  - `rd_valid` pulses for every read in the poll.
  - `rd_busy` stays high for the whole poll.
- Not defined:
  - `poll_req` is ignored.
  - `poll_done` and `poll_timeout` are tied to 0.
  - No poll counter is synthesized.

## Test plan
- Reset → all outputs at the listed reset values; `SF_E`=1; `LCD_RW`=0.
- `rd_req`, `rd_rs`=0; `lcd_din`=0x8 during E1 and 0x5 during E2 → `rd_valid` at k+129, `rd_data`=0x85, `busy_flag`=1, `LCD_RS`=0 throughout.
- `rd_rs`=1 data read → `LCD_RS`=1, `LCD_RW`=1 for 128 cycles, two E pulses of 12 cycles each; `busy_flag` unchanged.
- `rd_req` pulsed during EHI_H → ignored, single `rd_valid`. `rd_req` held high → next E rises `T_SETUP`+1 cycles after the prior DONE.
- `RST` during EHI_L → `LCD_E`=0 and `LCD_RW`=0 next cycle, no `rd_valid`, `rd_data` cleared.
- `LCD_BUSY_POLL_EN`:
  - BF=1 for 3 reads then 0 → 4 `rd_valid` pulses, `poll_done` on the 4th, `poll_timeout`=0.
  - `POLL_MAX`=4 with BF stuck at 1 → `poll_done` and `poll_timeout` both pulse after 4 reads.
